// File: rtl/pl_pkg.sv
// Shared pipeline definitions: control-bundle layout, WDSel encodings and the NOP control word.
package pl_pkg;

  localparam int unsigned CTRL_BUNDLE_W = 8;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_WDSEL    = 1;
  localparam int unsigned CTRL_WDSEL_W  = 2;
  localparam int unsigned CTRL_LOAD     = 3;
  localparam int unsigned CTRL_MEMWRITE = 4;

  typedef enum logic [1:0] {
    WDSEL_ALU = 2'd0,
    WDSEL_MEM = 2'd1,
    WDSEL_PC4 = 2'd2,
    WDSEL_IMM = 2'd3
  } wdsel_e;

  // Field order matches the bit offsets above (bit 0 = reg_write).
  typedef struct packed {
    logic [2:0] rsvd;
    logic       mem_write;
    logic       load;
    wdsel_e     wdsel;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    rsvd:      3'd0,
    mem_write: 1'b0,
    load:      1'b0,
    wdsel:     WDSEL_ALU,
    reg_write: 1'b0
  };

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle of one pipeline register; the stage owns the slave side.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DEPTH  = 1
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              stall;
  logic              flush;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DEPTH-1:0]  slot_valid;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  in_valid, in_data, in_ctrl, stall, flush,
    output in_ready, out_valid, out_data, out_ctrl, slot_valid, occupancy
  );

  modport master (
    output in_valid, in_data, in_ctrl, stall, flush,
    input  in_ready, out_valid, out_data, out_ctrl, slot_valid, occupancy
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid, data and control, with advance and flush.
module pipe_slot
  import pl_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv_i,
  input  logic              flush_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic [CTRL_W-1:0] src_ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;

  // Control from an invalid source is replaced so a bubble can never write back.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_RST;
    end else if (adv_i) begin
      valid_d = src_valid_i;
      data_d  = src_data_i;
      ctrl_d  = src_valid_i ? src_ctrl_i : CTRL_RST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_RST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised multi-slot pipeline register with stall, flush, optional bubble collapse and occupancy.
module pipe_stage_reg
  import pl_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 8,
  parameter int unsigned       DEPTH    = 1,
  parameter int unsigned       COLLAPSE = 0,
  parameter logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(CTRL_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   bus
);

  localparam int unsigned OCC_W       = $clog2(DEPTH + 1);
  localparam bit          COLLAPSE_EN = (COLLAPSE != 0);

  logic [DEPTH-1:0]  adv_c;
  logic [DEPTH-1:0]  slot_v;
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [CTRL_W-1:0] slot_ctrl [DEPTH];
  logic [DEPTH-1:0]  src_v;
  logic [DATA_W-1:0] src_data  [DEPTH];
  logic [CTRL_W-1:0] src_ctrl  [DEPTH];
  logic [OCC_W-1:0]  occ_c;

  // In collapse mode a slot may load when its content moves on or when it holds nothing.
  always_comb begin : p_adv
    logic carry;
    adv_c = '0;
    carry = COLLAPSE_EN ? (!bus.stall || !slot_v[DEPTH-1]) : !bus.stall;
    adv_c[DEPTH-1] = carry;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      carry    = COLLAPSE_EN ? (carry || !slot_v[k]) : !bus.stall;
      adv_c[k] = carry;
    end
  end

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_slot
    if (k == 0) begin : g_head
      assign src_v[k]    = bus.in_valid;
      assign src_data[k] = bus.in_data;
      assign src_ctrl[k] = bus.in_ctrl;
    end else begin : g_body
      assign src_v[k]    = slot_v[k-1];
      assign src_data[k] = slot_data[k-1];
      assign src_ctrl[k] = slot_ctrl[k-1];
    end

    pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .adv_i       (adv_c[k]),
      .flush_i     (bus.flush),
      .src_valid_i (src_v[k]),
      .src_data_i  (src_data[k]),
      .src_ctrl_i  (src_ctrl[k]),
      .valid_o     (slot_v[k]),
      .data_o      (slot_data[k]),
      .ctrl_o      (slot_ctrl[k])
    );
  end

  always_comb begin
    occ_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      occ_c = occ_c + OCC_W'(slot_v[k]);
    end
  end

  assign bus.in_ready   = adv_c[0] && !bus.flush;
  assign bus.out_valid  = slot_v[DEPTH-1];
  assign bus.out_data   = slot_data[DEPTH-1];
  assign bus.out_ctrl   = slot_ctrl[DEPTH-1];
  assign bus.slot_valid = slot_v;
  assign bus.occupancy  = occ_c;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three configurations sharing one clock and reset.
module tb_pipe_stage_reg;
  import pl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) if3  ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .DEPTH(2)) if2  ();
  pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) if3c ();

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .COLLAPSE(0), .CTRL_RST(8'h00))
    u3  (.clk(clk), .rst(rst), .bus(if3));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(2), .COLLAPSE(0), .CTRL_RST(8'h5A))
    u2  (.clk(clk), .rst(rst), .bus(if2));
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(3), .COLLAPSE(1), .CTRL_RST(8'h00))
    u3c (.clk(clk), .rst(rst), .bus(if3c));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    if3.in_valid  = 1'b0; if3.in_data  = '0; if3.in_ctrl  = '0; if3.stall  = 1'b0; if3.flush  = 1'b0;
    if2.in_valid  = 1'b0; if2.in_data  = '0; if2.in_ctrl  = '0; if2.stall  = 1'b0; if2.flush  = 1'b0;
    if3c.in_valid = 1'b0; if3c.in_data = '0; if3c.in_ctrl = '0; if3c.stall = 1'b0; if3c.flush = 1'b0;

    // Reset values
    step(); step();
    check("rst_out_valid", 64'(if3.out_valid), 64'd0);
    check("rst_out_data",  64'(if3.out_data),  64'd0);
    check("rst_out_ctrl",  64'(if3.out_ctrl),  64'(CTRL_NOP));
    check("rst_occ",       64'(if3.occupancy), 64'd0);
    check("rst_slot_valid",64'(if3.slot_valid),64'd0);
    check("rst_ctrl_d2",   64'(if2.out_ctrl),  64'h5A);
    check("rst_in_ready",  64'(if3.in_ready),  64'd1);
    if3c.stall = 1'b1;
    #1;
    check("rst_rdy_coll",  64'(if3c.in_ready), 64'd1);
    if3c.stall = 1'b0;

    // Pass-through A, B, C at depth 3
    rst = 1'b0;
    if3.in_valid = 1'b1; if3.in_data = 32'hA000_000A; if3.in_ctrl = 8'h13;
    step();
    check("pt_cap_slots",  64'(if3.slot_valid), 64'b001);
    check("pt_cap_outv",   64'(if3.out_valid),  64'd0);
    if3.in_data = 32'hB000_000B; if3.in_ctrl = 8'h25;
    step();
    check("pt_e2_outv",    64'(if3.out_valid),  64'd0);
    if3.in_data = 32'hC000_000C; if3.in_ctrl = 8'h37;
    step();
    if3.in_valid = 1'b0; if3.in_data = '0; if3.in_ctrl = '0;
    check("pt_a_valid",    64'(if3.out_valid),  64'd1);
    check("pt_a_data",     64'(if3.out_data),   64'hA000_000A);
    check("pt_a_ctrl",     64'(if3.out_ctrl),   64'h13);
    check("pt_occ3",       64'(if3.occupancy),  64'd3);
    step();
    check("pt_b_data",     64'(if3.out_data),   64'hB000_000B);
    check("pt_b_ctrl",     64'(if3.out_ctrl),   64'h25);
    check("pt_occ2",       64'(if3.occupancy),  64'd2);
    step();
    check("pt_c_data",     64'(if3.out_data),   64'hC000_000C);
    check("pt_occ1",       64'(if3.occupancy),  64'd1);
    step();
    check("pt_drain_v",    64'(if3.out_valid),  64'd0);
    check("pt_drain_ctrl", 64'(if3.out_ctrl),   64'h00);
    check("pt_drain_occ",  64'(if3.occupancy),  64'd0);

    // Stall hold at depth 2
    if2.in_valid = 1'b1; if2.in_data = 32'hD; if2.in_ctrl = 8'h21;
    step();
    if2.in_data = 32'hE; if2.in_ctrl = 8'h42;
    step();
    check("st_full_data",  64'(if2.out_data),   64'hD);
    check("st_full_occ",   64'(if2.occupancy),  64'd2);
    if2.in_data = 32'hF; if2.in_ctrl = 8'h84; if2.stall = 1'b1;
    #1;
    check("st_rdy0",       64'(if2.in_ready),   64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_hold_data", 64'(if2.out_data),  64'hD);
      check("st_hold_occ",  64'(if2.occupancy), 64'd2);
      check("st_hold_rdy",  64'(if2.in_ready),  64'd0);
    end
    if2.stall = 1'b0;
    step();
    check("st_next_data",  64'(if2.out_data),   64'hE);
    check("st_next_ctrl",  64'(if2.out_ctrl),   64'h42);
    check("st_next_occ",   64'(if2.occupancy),  64'd2);
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_ctrl = '0;
    step();
    check("st_f_data",     64'(if2.out_data),   64'hF);
    check("st_f_ctrl",     64'(if2.out_ctrl),   64'h84);
    step();
    check("st_empty_ctrl", 64'(if2.out_ctrl),   64'h5A);
    check("st_empty_occ",  64'(if2.occupancy),  64'd0);

    // Bubble control: invalid input with all-ones control
    if2.in_valid = 1'b0; if2.in_data = 32'hBEEF; if2.in_ctrl = 8'hFF;
    step();
    if2.in_data = '0; if2.in_ctrl = '0;
    step();
    check("bub_valid",     64'(if2.out_valid),  64'd0);
    check("bub_ctrl",      64'(if2.out_ctrl),   64'h5A);
    check("bub_data",      64'(if2.out_data),   64'hBEEF);

    // Bubble collapse: build valid/empty/valid then stall
    if3c.in_valid = 1'b1; if3c.in_data = 32'h6; if3c.in_ctrl = 8'h0F;
    step();
    if3c.in_valid = 1'b0; if3c.in_data = '0; if3c.in_ctrl = '0;
    step();
    if3c.in_valid = 1'b1; if3c.in_data = 32'h7; if3c.in_ctrl = 8'h1E;
    step();
    check("col_pattern",   64'(if3c.slot_valid), 64'b101);
    check("col_pre_data",  64'(if3c.out_data),   64'h6);
    if3c.stall = 1'b1; if3c.in_data = 32'h8; if3c.in_ctrl = 8'h2D;
    #1;
    check("col_rdy1",      64'(if3c.in_ready),   64'd1);
    step();
    check("col_slots",     64'(if3c.slot_valid), 64'b111);
    check("col_out_data",  64'(if3c.out_data),   64'h6);
    check("col_out_ctrl",  64'(if3c.out_ctrl),   64'h0F);
    check("col_occ",       64'(if3c.occupancy),  64'd3);
    check("col_full_rdy",  64'(if3c.in_ready),   64'd0);

    // Flush beats stall on a full pipeline
    if3c.flush = 1'b1; if3c.in_data = 32'h9; if3c.in_ctrl = 8'h3C;
    #1;
    check("fl_rdy0",       64'(if3c.in_ready),   64'd0);
    step();
    check("fl_slots",      64'(if3c.slot_valid), 64'd0);
    check("fl_out_valid",  64'(if3c.out_valid),  64'd0);
    check("fl_out_ctrl",   64'(if3c.out_ctrl),   64'h00);
    check("fl_out_data",   64'(if3c.out_data),   64'h6);
    check("fl_occ",        64'(if3c.occupancy),  64'd0);
    if3c.flush = 1'b0; if3c.stall = 1'b0; if3c.in_valid = 1'b0;

    // Reset mid-stall at depth 3
    if3.in_valid = 1'b1; if3.in_data = 32'h11; if3.in_ctrl = 8'h01;
    step();
    if3.in_data = 32'h22; if3.in_ctrl = 8'h02;
    step();
    if3.in_data = 32'h33; if3.in_ctrl = 8'h03;
    step();
    check("rm_full_occ",   64'(if3.occupancy),  64'd3);
    if3.stall = 1'b1; if3.in_data = 32'h44; if3.in_ctrl = 8'h04;
    step();
    check("rm_hold_data",  64'(if3.out_data),   64'h11);
    rst = 1'b1;
    step();
    check("rm_valid",      64'(if3.out_valid),  64'd0);
    check("rm_data",       64'(if3.out_data),   64'd0);
    check("rm_ctrl",       64'(if3.out_ctrl),   64'd0);
    check("rm_slots",      64'(if3.slot_valid), 64'd0);
    rst = 1'b0; if3.stall = 1'b0;
    #1;
    check("rm_rdy",        64'(if3.in_ready),   64'd1);
    step();
    if3.in_valid = 1'b0; if3.in_data = '0; if3.in_ctrl = '0;
    check("rm_capture",    64'(if3.slot_valid), 64'b001);
    step(); step();
    check("rm_lat_data",   64'(if3.out_data),   64'h44);
    check("rm_lat_ctrl",   64'(if3.out_ctrl),   64'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
